// File: rtl/display_scanner.sv
// display_scanner: latches the syscall display register on a load strobe,
// optionally converts it to unsigned decimal with an iterative double-dabble
// FSM, and drives an 8-digit multiplexed active-low 7-segment display.
module display_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] din,
  input  logic        dec_mode,
  input  logic        blank_zeros,
  output logic        busy,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   sh_q, sh_d;
  logic [39:0]   bcd_q, bcd_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    nib;
  logic [31:0]   upper;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [39:0] dabble_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Load acceptance, conversion steps and commit of the display buffer.
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (dec_mode) begin
            state_d = S_CONV;
            sh_d    = din;
            bcd_d   = '0;
            cnt_d   = '0;
          end else begin
            disp_d = din;
            ovf_d  = 1'b0;
          end
        end
      end
      S_CONV: begin
        {bcd_d, sh_d} = {dabble_adjust(bcd_q), sh_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_d  = bcd_q[31:0];
        ovf_d   = |bcd_q[39:32];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Digit slot timing and the next registered digit/segment pattern.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_MAX) begin
      pre_d = '0;
      idx_d = idx_q + 3'd1;
    end
    nib   = disp_q[4*idx_q +: 4];
    upper = disp_q >> {idx_q, 2'b00};
    an_d  = ~(8'd1 << idx_q);
    if (blank_zeros && (idx_q != 3'd0) && (upper == 32'd0)) seg_d = 7'h7F;
    else                                                     seg_d = seg_decode(nib);
    dp_d  = ~((idx_q == 3'd7) && ovf_q);
  end

  // Control, buffer and scan registers; reset aborts any conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= 8'hFE;
      seg_q   <= 7'h40;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  // Conversion datapath; only meaningful while converting, so it carries no reset.
  always_ff @(posedge clk) begin
    sh_q  <= sh_d;
    bcd_q <= bcd_d;
  end

  assign busy = (state_q != S_IDLE);
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;

endmodule
